multi_button_debouncer: RTL

Parametrised N-channel successor to the single-button debouncer. Each channel synchronises a raw pushbutton, qualifies press and release with independent stable-time windows, and emits a debounced level plus one-cycle press, release and auto-repeat pulses. It sits between the board buttons and the game/menu control logic, replacing one debouncer instance per button.

---
 rtl/multi_button_debouncer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer: N independent pushbutton debouncers.
// Each channel passes its raw button through a 2-flop synchroniser. It then qualifies press
// and release with separate stable-time windows. While the button is held it can emit
// auto-repeat pulses.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   BTN            in   raw asynchronous buttons, bit i = channel i
//   level          out  debounced button state
//   press          out  one-cycle pulse on accepted press
//   release_pulse  out  one-cycle pulse on accepted release
//   repeat_pulse   out  one-cycle pulse per auto-repeat interval while held
// The last two carry a _pulse suffix because release/repeat are reserved words.
module multi_button_debouncer #(
  parameter int unsigned N_BTN          = 5,
  parameter int unsigned PRESS_CYCLES   = 2000,
  parameter int unsigned RELEASE_CYCLES = 2000,
  parameter int unsigned HOLD_CYCLES    = 24000,
  parameter int unsigned REPEAT_CYCLES  = 8000,
  parameter bit          REPEAT_EN      = 1'b1,
  parameter int unsigned CNT_W          = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] BTN,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam logic [CNT_W-1:0] PressLast   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ReleaseLast = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepeatLast  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic             sync1_q, s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;  // 1: next repeat uses HOLD window
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             rpt_q, rpt_d;
    logic [CNT_W-1:0] held_last;

    assign held_last = first_q ? HoldLast : RepeatLast;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rpt_d   = 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (s_q) state_d = StPressWait;
        end
        StPressWait: begin
          if (!s_q) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == PressLast) begin
            state_d = StHeld;
            press_d = 1'b1;
            level_d = 1'b1;
            cnt_d   = '0;
            first_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StHeld: begin
          if (!s_q) begin
            state_d = StReleaseWait;
            cnt_d   = '0;
          end else if (cnt_q == held_last) begin
            // With repeat disabled the counter parks at the limit instead of wrapping.
            if (REPEAT_EN) begin
              rpt_d   = 1'b1;
              cnt_d   = '0;
              first_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StReleaseWait: begin
          if (s_q) begin
            // Bounce back to held: repeat timing restarts from the long window.
            state_d = StHeld;
            cnt_d   = '0;
            first_d = 1'b1;
          end else if (cnt_q == ReleaseLast) begin
            state_d = StIdle;
            level_d = 1'b0;
            rel_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q <= 1'b0;
        s_q     <= 1'b0;
        state_q <= StIdle;
        cnt_q   <= '0;
        first_q <= 1'b1;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        sync1_q <= BTN[i];
        s_q     <= sync1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        first_q <= first_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        rpt_q   <= rpt_d;
      end
    end

    assign level[i]         = level_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = rel_q;
    assign repeat_pulse[i]  = rpt_q;
  end

endmodule
